// File: rtl/cacheline_adapter.sv
// Cache-line to 64-bit DRAM burst adapter.
// One line read or write per request, one umem_resp per completed transfer.
module cacheline_adapter #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          umem_addr,
  input  logic                 umem_read,
  input  logic                 umem_write,
  input  logic [LINE_BITS-1:0] umem_wdata,
  output logic [LINE_BITS-1:0] umem_rdata,
  output logic                 umem_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BURST,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0][BEAT_BITS-1:0] wbuf_q, wbuf_d;
  logic [3:0][BEAT_BITS-1:0] line_q, line_d;
  logic [3:0][BEAT_BITS-1:0] rdata_q, rdata_d;
  logic [31:0] line_addr;
  logic        beat_hit;
  logic        addr_unused;

  // Offset bits within the line never reach DRAM.
  assign addr_unused = ^umem_addr[4:0];
  assign line_addr   = {umem_addr[31:5], 5'b0};
  assign beat_hit    = bmem_rvalid && (bmem_raddr == addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (umem_write) begin
          addr_d  = line_addr;
          wbuf_d  = umem_wdata;
          cnt_d   = 2'd0;
          state_d = WR_BURST;
        end else if (umem_read) begin
          addr_d  = line_addr;
          cnt_d   = 2'd0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bmem_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (beat_hit) begin
          line_d[cnt_q] = bmem_rdata;
          // Publish the line only once complete so umem_rdata holds the old line until then.
          if (cnt_q == 2'd3) begin
            rdata_d = line_d;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          if (cnt_q == 2'd3) state_d = RESP;
          else cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  assign bmem_read  = (state_q == RD_REQ);
  assign bmem_write = (state_q == WR_BURST);
  assign umem_resp  = (state_q == RESP);
  assign bmem_addr  = addr_q;
  assign bmem_wdata = bmem_write ? wbuf_q[cnt_q] : '0;
  assign umem_rdata = rdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter.
// A transaction-level model predicts beats, lines and resp timing.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  umem_addr;
  logic         umem_read;
  logic         umem_write;
  logic [255:0] umem_wdata;
  logic [255:0] umem_rdata;
  logic         umem_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_rdata;

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .umem_addr  (umem_addr),
    .umem_read  (umem_read),
    .umem_write (umem_write),
    .umem_wdata (umem_wdata),
    .umem_rdata (umem_rdata),
    .umem_resp  (umem_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // pat: 2-bit code per data cycle: 0/3 beat, 1 gap, 2 foreign beat
  task automatic do_read(input logic [31:0] a, input logic [255:0] line,
                         input logic [31:0] req_lo, input logic [31:0] pat);
    logic [31:0] la;
    logic [1:0]  code;
    int beat = 0, d = 0, rq = 0, exp_cyc = -1, bad = 0;
    bit pend = 1, in_data = 0, done = 0;
    la = {a[31:5], 5'b0};
    umem_addr  = a;
    umem_read  = 1'b1;
    umem_write = 1'b0;
    step();
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      if (umem_resp) begin
        check("rd_lat", cyc, exp_cyc);
        check("rd_data", umem_rdata, line);
        exp_rdata = line;
        done = 1;
        umem_read = 1'b0;
      end else begin
        bad += (bmem_read !== pend) || (bmem_write !== 1'b0) ||
               (bmem_addr !== la) || (umem_rdata !== exp_rdata);
      end
      bmem_rvalid = 1'b0;
      bmem_raddr  = $urandom;
      bmem_rdata  = {$urandom, $urandom};
      bmem_ready  = 1'($urandom_range(0, 1));
      if (!done && pend) begin
        bmem_ready  = (rq < 32) ? !req_lo[rq] : 1'b1;
        rq++;
        bmem_rvalid = 1'($urandom_range(0, 1));
        bmem_raddr  = la;
        if (bmem_ready) pend = 0;
      end else if (!done && in_data && beat < 4) begin
        code = (d < 16) ? pat[2*d +: 2] : 2'd0;
        d++;
        case (code)
          2'd1: bmem_rvalid = 1'b0;
          2'd2: begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = la + 32'h20;
          end
          default: begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = la;
            bmem_rdata  = line[64*beat +: 64];
            beat++;
            if (beat == 4) exp_cyc = cyc + 1;
          end
        endcase
      end
      in_data = !pend;
      step();
    end
    if (!done) check("rd_timeout", 0, 1);
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b0;
    check("rd_cycles", bad, 0);
    check("rd_after", {umem_resp, bmem_read, bmem_write}, 0);
  endtask

  // lo: bit c set => bmem_ready low in cycle c
  task automatic do_write(input logic [31:0] a, input logic [255:0] line,
                          input logic [31:0] lo, input bit both);
    logic [31:0] la;
    int idx = 0, exp_cyc = -1, bad = 0;
    bit done = 0;
    la = {a[31:5], 5'b0};
    umem_addr  = a;
    umem_wdata = line;
    umem_write = 1'b1;
    umem_read  = both;
    step();
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      if (umem_resp) begin
        check("wr_lat", cyc, exp_cyc);
        check("wr_rdata", umem_rdata, exp_rdata);
        done = 1;
        umem_write = 1'b0;
        umem_read  = 1'b0;
      end else if (idx < 4) begin
        bad += (bmem_write !== 1'b1) || (bmem_read !== 1'b0) ||
               (bmem_addr !== la) || (bmem_wdata !== line[64*idx +: 64]);
      end else begin
        bad += (bmem_write !== 1'b0);
      end
      bmem_ready  = (cyc < 32) ? !lo[cyc] : 1'b1;
      bmem_rvalid = 1'($urandom_range(0, 1));
      bmem_raddr  = la;
      bmem_rdata  = {$urandom, $urandom};
      if (!done && bmem_ready && idx < 4) begin
        idx++;
        if (idx == 4) exp_cyc = cyc + 1;
      end
      step();
    end
    if (!done) check("wr_timeout", 0, 1);
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b0;
    check("wr_cycles", bad, 0);
    check("wr_after", {umem_resp, bmem_read, bmem_write}, 0);
  endtask

  initial begin
    logic [255:0] l;
    int bad;
    rst = 1'b1;
    umem_addr = '0;
    umem_read = 1'b0;
    umem_write = 1'b0;
    umem_wdata = '0;
    bmem_ready = 1'b0;
    bmem_raddr = '0;
    bmem_rdata = 64'hdead_beef_dead_beef;
    bmem_rvalid = 1'b1;
    exp_rdata = '0;
    step();
    step();
    check("rst_ctl", {umem_resp, bmem_read, bmem_write}, 0);
    check("rst_bus", {bmem_addr, bmem_wdata}, 0);
    check("rst_rdata", umem_rdata, 0);
    rst = 1'b0;
    step();
    bmem_rvalid = 1'b0;
    check("post_rst", {umem_resp, bmem_read, bmem_write, bmem_addr}, 0);
    check("post_rst_rdata", umem_rdata, 0);

    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, l, 32'h0, 32'h0);

    do_write(32'h0000_0040, rand_line(), 32'hC, 1'b0);

    do_read(32'h0000_0080, rand_line(), 32'h0, 32'h90);

    do_write(32'h0000_0300, rand_line(), $urandom & $urandom, 1'b1);
    do_read(32'h0000_1340, rand_line(), 32'h2, $urandom);

    l = rand_line();
    umem_addr  = 32'h0000_0100;
    umem_wdata = l;
    umem_write = 1'b1;
    bmem_ready = 1'b1;
    step();
    step();
    check("mb_beat1", bmem_wdata, l[127:64]);
    rst = 1'b1;
    step();
    umem_write = 1'b0;
    exp_rdata  = '0;
    check("mb_ctl", {umem_resp, bmem_read, bmem_write}, 0);
    check("mb_bus", {bmem_addr, bmem_wdata}, 0);
    check("mb_rdata", umem_rdata, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0;
      bmem_rdata  = {$urandom, $urandom};
      step();
      bad += umem_resp || bmem_write || bmem_read || (umem_rdata !== '0);
    end
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b0;
    check("mb_quiet", bad, 0);
    do_read(32'h0000_0100, rand_line(), 32'h0, 32'h0);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, rand_line(), $urandom & $urandom, 1'($urandom_range(0, 1)));
      else
        do_read($urandom, rand_line(), $urandom & $urandom & 32'hF, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Bridges the cache arbiter's single-line memory port (`umem_*`, 256-bit lines) to the 64-bit burst DRAM port (`bmem_*`). It sits directly downstream of the arbiter. A line read is one DRAM read request followed by a 4-beat return. A line write is a 4-beat burst. Each completed transaction produces exactly one `umem_resp` pulse to the arbiter.

## Interface
Parameters:
- `LINE_BITS`, 256: cache line width. Fixed; `LINE_BITS = 4*BEAT_BITS`.
- `BEAT_BITS`, 64: DRAM beat width.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `umem_addr` in 32: line address; valid while `umem_read` or `umem_write` is high.
- `umem_read` in 1: line read request, level-held until `umem_resp`.
- `umem_write` in 1: line write request, level-held until `umem_resp`.
- `umem_wdata` in 256: write line; beat k = bits [64k+63:64k].
- `umem_rdata` out 256: read line; valid in the `umem_resp` cycle; held until the next read completes.
- `umem_resp` out 1: one-cycle completion pulse.
- `bmem_addr` out 32: burst address, always `{umem_addr[31:5],5'b0}`.
- `bmem_read` out 1: read request.
- `bmem_write` out 1: write beat valid.
- `bmem_wdata` out 64: current write beat.
- `bmem_ready` in 1: DRAM accepts the request or beat this cycle.
- `bmem_raddr` in 32: address tag of the returning beat.
- `bmem_rdata` in 64: returning beat data.
- `bmem_rvalid` in 1: a return beat is present.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP.
- **IDLE**
  - On `umem_write`: latch the line address and `umem_wdata` into the write buffer; set beat counter to 0; go to WR_BURST.
  - Otherwise, on `umem_read`: latch the line address; clear the beat counter; go to RD_REQ.
  - If both are high, the write wins.
- **RD_REQ**
  - `bmem_read=1` and `bmem_addr` is driven.
  - When `bmem_ready=1` at the edge, the request is accepted; go to RD_DATA.
  - Otherwise hold the request.
- **RD_DATA**
  - Each cycle with `bmem_rvalid=1` and `bmem_raddr` equal to the latched line address stores `bmem_rdata` into line slice [counter].
  - The counter increments on each stored beat.
  - Beats with a mismatched `raddr` are dropped.
  - After beat 3 is stored, go to RESP.
- **WR_BURST**
  - `bmem_write=1`; `bmem_addr` is the line address on every beat.
  - `bmem_wdata` = buffered slice [counter].
  - The counter advances only on edges with `bmem_ready=1`.
  - After beat 3 is accepted, go to RESP.
- **RESP**
  - `umem_resp=1` for exactly one cycle, then return to IDLE.
  - `umem_rdata` is updated only by reads; a write leaves it unchanged.
- `bmem_read` and `bmem_write` are never high together.
- `bmem_rvalid` seen outside RD_DATA is ignored.
- The beat counter is 2 bits and never wraps within a transaction; it resets on entry to RD_REQ/WR_BURST.
- **Reset** (any cycle, including mid-burst):
  - State goes to IDLE.
  - `umem_resp`, `bmem_read`, `bmem_write` = 0.
  - `bmem_addr`, `bmem_wdata`, `umem_rdata` = 0.
  - Beats arriving after reset are ignored.
  - An interrupted transaction produces no `umem_resp`.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `umem_*` to `bmem_*`.
- **Read latency**:
  - IDLE captures the request at edge 0; `bmem_read` is high from cycle 1.
  - With `bmem_ready=1`, the request is accepted at edge 1.
  - The 4th valid beat is stored at edge N; `umem_resp=1` in cycle N+1.
- **Write latency**:
  - `bmem_write` is high from cycle 1.
  - With `bmem_ready` continuously high, beats 0..3 go out in cycles 1..4 and `umem_resp=1` in cycle 5 (minimum 5 cycles).
  - Each low-`ready` cycle adds one cycle.
- **Back-to-back**:
  - The arbiter deasserts its request at the edge ending the resp cycle, so IDLE sees no request that cycle.
  - The next request can be captured one cycle after RESP.
  - A request still high in IDLE after RESP is treated as new.
- Non-contiguous `rvalid` beats are legal; gaps only stall RD_DATA.

## Test plan
- **Reset**: hold `rst` 2 cycles.
  - All outputs must be 0 and the state IDLE.
  - `bmem_rvalid` pulsed during reset must have no effect.
- **Single read**: `umem_read`, `addr=0x0000_1234`.
  - Expect `bmem_addr=0x0000_1220` and `bmem_read` for one cycle with ready.
  - Return beats `0x11..1, 0x22..2, 0x33..3, 0x44..4`.
  - Expect one `umem_resp` with `umem_rdata={0x44..4,0x33..3,0x22..2,0x11..1}`, 1 cycle after the last beat.
- **Write with stall**: `umem_write`, `addr=0x40`, `wdata` slices A,B,C,D; `bmem_ready` low on the 2nd beat for 2 cycles.
  - Expect `wdata` sequence A, B, B, B, C, D with `bmem_write` high throughout.
  - Expect `umem_resp` 7 cycles after capture.
  - `umem_rdata` must be unchanged.
- **Gapped/foreign beats on read**: read `0x80`.
  - Insert an idle cycle between beats 1 and 2.
  - Inject one beat with `raddr=0xA0`.
  - Expect only the 4 matching beats in the line and a single `umem_resp`.
- **Simultaneous and back-to-back**:
  - Assert `umem_read` and `umem_write` together: expect a write burst first.
  - Then immediately issue a read after RESP: expect `bmem_read` 1 cycle after IDLE capture and no duplicate `bmem_read` or `umem_resp`.
- **Reset mid-burst**: assert `rst` after write beat 1.
  - Expect `bmem_write=0` the next cycle and no `umem_resp`.
  - A following read must complete normally.
